imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts an instruction word plus a 3-bit immediate-format select over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width through a registered output stage with a one-entry skid buffer. It supports all six base-ISA immediate formats, flags illegal format selects, and honours a pipeline flush.

## Interface
Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64 only.
- TAG_W, 32, width of the sideband tag carried alongside the instruction (typically the PC).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  discards all held entries at the next edge.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  the block can accept an entry this cycle.
- in_instr  input  32  raw instruction word.
- in_imm_src  input  3  format select (encodings in Operation).
- in_tag  input  TAG_W  sideband passed through unchanged.
- out_valid  output  1  output entry present.
- out_ready  input  1  downstream accepts the entry.
- out_imm  output  XLEN  extended immediate.
- out_instr  output  32  instruction passed through.
- out_tag  output  TAG_W  tag passed through.
- out_illegal  output  1  the entry's in_imm_src was a reserved encoding.

## Operation
- Format encodings:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: sext({instr[31:12], 12'b0}).
  - 101 Z: zext(instr[19:15]), the CSR uimm.
  - 110 and 111 are reserved: imm = 0 and out_illegal = 1.
- sext replicates instr[31] up to bit XLEN-1. With XLEN=32 the U format has no extension bits. With XLEN=64 the U format sign-extends bit 31.
- Storage: main register (M) drives the outputs; skid register (K) holds one overflow entry. Each register has its own valid bit.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- in_ready = !K.valid. It is purely a function of registered state; there is no combinational path from out_ready.
- Per edge, when there is no flush:
  - Output transfer with K.valid: M <= K and K is cleared. No input is accepted that cycle, because in_ready was 0.
  - Output transfer with !K.valid: M <= input if an input transfer occurs; otherwise M.valid <= 0.
  - M.valid && !out_ready with an input transfer: K <= input.
  - !M.valid with an input transfer: M <= input.
- Flush: M.valid and K.valid clear at the next edge. An input transferred in the same cycle is discarded. out_valid may still be 1 during the flush cycle; downstream must ignore it.
- Order is strictly FIFO. No entry is duplicated or dropped, except by flush.

## Timing
- Latency is 1 cycle: an input transferred at edge n is visible on out_* after edge n when M was free or drained at that edge.
- Sustained throughput is 1 entry/cycle while out_ready = 1.
- After the first stall cycle in_ready falls (K full) and stays low until K drains into M.
- Reset values: out_valid = 0, out_imm = 0, out_instr = 0, out_tag = 0, out_illegal = 0, in_ready = 1. Both valid bits clear immediately on rst_n falling, independent of clk.
- Payload registers load only on transfers, so out_* are stable while out_valid && !out_ready.
- The decode is combinational on the input side and registered into M/K, so there is no logic after M.

## Structure
- Package imm_pkg:
  - imm_src_e enum: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z.
  - IMM_SRC_W = 3.
  - An entry struct with fields imm, instr, tag, illegal, parametrised via XLEN/TAG_W at use.
- Sub-module imm_decode: purely combinational. Inputs are instr and imm_src; outputs are imm[XLEN-1:0] and illegal. It is instantiated once, on the input side.
- imm_gen_pipe contains only the M/K registers and the handshake logic.
- An elaboration-time check fails when XLEN is neither 32 nor 64.

## Test plan
- Formats at XLEN=32:
  - I with 0xFFF00093 -> 0xFFFFFFFF.
  - S with 0xFE20AE23 -> 0xFFFFFFFC.
  - B with 0xFE000EE3 -> 0xFFFFFFFC.
  - J with 0xFF9FF06F -> 0xFFFFFFF8.
  - U with 0x123450B7 -> 0x12345000.
  - Z with 0x0007D073 -> 0x0000000F.
- XLEN=64:
  - U with 0x800000B7 -> 0xFFFFFFFF80000000.
  - I with 0x7FF00093 -> 0x00000000000007FF.
- Illegal select: in_imm_src = 110 with any instruction -> out_imm = 0, out_illegal = 1; the next entry with 000 -> out_illegal = 0.
- Backpressure: hold out_ready = 0 and offer tags 1, 2, 3 back-to-back.
  - Required: tag 1 in M, tag 2 in K, in_ready = 0 and tag 3 held upstream.
  - Release out_ready: tags emerge in order 1, 2, 3, one per cycle after the first, with no duplicates.
- Flush: with M and K both valid and a valid input offered, assert flush for 1 cycle.
  - Required: the next cycle out_valid = 0 and in_ready = 1; the flushed tags never appear.
- Reset mid-stream: drop rst_n between clk edges while M and K are full.
  - Required: out_valid = 0 and in_ready = 1 immediately.
  - After release, the first new input appears 1 cycle after acceptance.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate generator pipeline.
// Format select encoding and its width.
package imm_pkg;

  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4,
    IMM_Z = 3'd5
  } imm_src_e;

  function automatic logic is_reserved(
    input logic [IMM_SRC_W-1:0] s
  );
    return s > IMM_SRC_W'(IMM_Z);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instr + format select -> imm, illegal.
// Ports: instr[31:0], imm_src[2:0] in; imm[XLEN-1:0], illegal out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  logic [31:0] raw;

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    unique case (imm_src_e'(imm_src))
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_J: raw = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
      IMM_Z: raw = {27'b0, instr[19:15]};
      default: illegal = 1'b1;
    endcase
    // raw[31] is the sign for every format (0 for Z),
    // so one signed widen covers both XLEN choices.
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with registered output (M) and one-entry skid (K).
// Ports: in_* valid/ready upstream, out_* valid/ready downstream, flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [31:0]          out_instr,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t in_e;
  entry_t m_q, m_d;
  entry_t k_q, k_d;
  logic   m_vld_q, m_vld_d;
  logic   k_vld_q, k_vld_d;
  logic   in_xfer, out_xfer;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (in_e.imm),
    .illegal (in_e.illegal)
  );

  assign in_e.instr = in_instr;
  assign in_e.tag   = in_tag;

  assign in_ready = !k_vld_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = m_vld_q && out_ready;

  always_comb begin
    m_d     = m_q;
    k_d     = k_q;
    m_vld_d = m_vld_q;
    k_vld_d = k_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end else if (!m_vld_q || out_xfer) begin
      // K is only ever full while M is full
      if (k_vld_q) begin
        m_d     = k_q;
        k_vld_d = 1'b0;
      end else if (in_xfer) begin
        m_d     = in_e;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      k_d     = in_e;
      k_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end

  assign out_valid   = m_vld_q;
  assign out_imm     = m_q.imm;
  assign out_instr   = m_q.instr;
  assign out_tag     = m_q.tag;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared inputs.
// Directed format/handshake steps, then random traffic vs a FIFO model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm, a_instr, a_tag;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_imm;
  logic [31:0] b_instr, b_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src),
    .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_imm),
    .out_instr(a_instr), .out_tag(a_tag),
    .out_illegal(a_ill)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src),
    .in_tag(in_tag), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_imm(b_imm),
    .out_instr(b_instr), .out_tag(b_tag),
    .out_illegal(b_ill)
  );

  typedef struct {
    logic [63:0] imm;
    logic [31:0] instr;
    logic [31:0] tag;
    logic        ill;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference immediate from field arithmetic, as a 64-bit value
  function automatic logic [63:0] ref_imm(
    input logic [31:0] w, input logic [2:0] s,
    output logic ill);
    longint v;
    longint f;
    ill = 1'b0;
    v = 0;
    case (s)
      3'd0: begin
        f = longint'(w[31:20]);
        v = f - (w[31] ? 64'd4096 : 64'd0);
      end
      3'd1: begin
        f = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        v = f - (w[31] ? 64'd4096 : 64'd0);
      end
      3'd2: begin
        f = longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32
          + longint'(w[11:8]) * 2;
        v = f - (w[31] ? 64'd4096 : 64'd0);
      end
      3'd3: begin
        f = longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048
          + longint'(w[30:21]) * 2;
        v = f - (w[31] ? 64'd1048576 : 64'd0);
      end
      3'd4: begin
        f = longint'(w[30:12]) * 4096;
        v = f - (w[31] ? 64'h8000_0000 : 64'd0);
      end
      3'd5: v = longint'(w[19:15]);
      default: begin
        v = 0;
        ill = 1'b1;
      end
    endcase
    return 64'(v);
  endfunction

  task automatic chk_state();
    bit er;
    er = q.size() < 2;
    chk("rdy32", 64'(a_in_ready), 64'(er));
    chk("rdy64", 64'(b_in_ready), 64'(er));
    chk("vld32", 64'(a_out_valid), 64'(q.size() > 0));
    chk("vld64", 64'(b_out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm32", 64'(a_imm), 64'(q[0].imm[31:0]));
      chk("imm64", b_imm, q[0].imm);
      chk("instr32", 64'(a_instr), 64'(q[0].instr));
      chk("tag32", 64'(a_tag), 64'(q[0].tag));
      chk("tag64", 64'(b_tag), 64'(q[0].tag));
      chk("ill32", 64'(a_ill), 64'(q[0].ill));
      chk("ill64", 64'(b_ill), 64'(q[0].ill));
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins,
                     input logic [2:0] s,
                     input logic [31:0] t,
                     input bit ordy, input bit fl);
    bit   er;
    ent_t e;
    @(negedge clk);
    in_valid   = v;
    in_instr   = ins;
    in_imm_src = s;
    in_tag     = t;
    out_ready  = ordy;
    flush      = fl;
    #1;
    chk_state();
    er = q.size() < 2;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (v && er) begin
        e.imm   = ref_imm(ins, s, e.ill);
        e.instr = ins;
        e.tag   = t;
        q.push_back(e);
      end
    end
  endtask

  logic [31:0] f_ins [6] = '{32'hFFF00093, 32'hFE20AE23,
    32'hFE000EE3, 32'hFF9FF06F, 32'h123450B7, 32'h0007D073};
  logic [31:0] f_exp [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC,
    32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h0000000F};

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    out_ready  = 1'b0;
    #2;
    chk("rst_vld", 64'(a_out_valid), 64'd0);
    chk("rst_rdy", 64'(a_in_ready), 64'd1);
    chk("rst_imm", b_imm, 64'd0);
    chk("rst_instr", 64'(a_instr), 64'd0);
    chk("rst_tag", 64'(a_tag), 64'd0);
    chk("rst_ill", 64'(a_ill), 64'd0);
    #20;
    rst_n = 1'b1;

    // formats, XLEN=32 constants
    for (int i = 0; i < 6; i++) begin
      cyc(1, f_ins[i], 3'(i), 32'(i + 100), 1, 0);
      #2;
      chk($sformatf("fmt%0d", i), 64'(a_imm), 64'(f_exp[i]));
    end
    // XLEN=64 constants
    cyc(1, 32'h800000B7, 3'd4, 32'd200, 1, 0);
    #2;
    chk("u64", b_imm, 64'hFFFFFFFF80000000);
    cyc(1, 32'h7FF00093, 3'd0, 32'd201, 1, 0);
    #2;
    chk("i64", b_imm, 64'h00000000000007FF);
    // illegal select, then legal
    cyc(1, 32'hDEADBEEF, 3'd6, 32'd202, 1, 0);
    #2;
    chk("ill_imm", b_imm, 64'd0);
    chk("ill_flag", 64'(a_ill), 64'd1);
    cyc(1, 32'hDEADBEEF, 3'd0, 32'd203, 1, 0);
    #2;
    chk("ill_clr", 64'(a_ill), 64'd0);
    cyc(0, 0, 0, 0, 1, 0);

    // backpressure
    cyc(1, 32'h00100093, 0, 32'd1, 0, 0);
    cyc(1, 32'h00200093, 0, 32'd2, 0, 0);
    cyc(1, 32'h00300093, 0, 32'd3, 0, 0);
    #2;
    chk("bp_rdy", 64'(a_in_ready), 64'd0);
    chk("bp_m", 64'(a_tag), 64'd1);
    cyc(1, 32'h00300093, 0, 32'd3, 1, 0);
    #2;
    chk("bp_o2", 64'(a_tag), 64'd2);
    cyc(1, 32'h00300093, 0, 32'd3, 1, 0);
    #2;
    chk("bp_o3", 64'(a_tag), 64'd3);
    cyc(0, 0, 0, 0, 1, 0);
    #2;
    chk("bp_end", 64'(a_out_valid), 64'd0);

    // flush with M, K and input all live
    cyc(1, 32'h00A00093, 0, 32'd10, 0, 0);
    cyc(1, 32'h00B00093, 0, 32'd11, 0, 0);
    cyc(1, 32'h00C00093, 0, 32'd12, 0, 1);
    #2;
    chk("fl_vld", 64'(a_out_valid), 64'd0);
    chk("fl_rdy", 64'(b_in_ready), 64'd1);
    cyc(0, 0, 0, 0, 1, 0);

    // async reset mid-stream
    cyc(1, 32'h01400093, 0, 32'd20, 0, 0);
    cyc(1, 32'h01500093, 0, 32'd21, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(a_out_valid), 64'd0);
    chk("ar_rdy", 64'(a_in_ready), 64'd1);
    chk("ar_vld64", 64'(b_out_valid), 64'd0);
    q.delete();
    #1;
    rst_n = 1'b1;
    cyc(1, 32'h01E00093, 0, 32'd30, 1, 0);
    #2;
    chk("ar_lat", 64'(a_out_valid), 64'd1);
    chk("ar_tag", 64'(a_tag), 64'd30);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom,
          3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
